operand_delivery_queue: RTL and testbench

- Sits between the operand network router port of an E-node and that node's reservation station.
- Buffers incoming operand packets (operand, dest instr number, dest slot) in a small FIFO.
- Delivers packets one at a time over the station's single-cycle req / registered-ack handshake, retrying on missing ack and dropping after a retry budget.
- Supports flush on block commit/revitalize, and exposes occupancy plus drop/error status to the node controller.

---
 rtl/operand_delivery_queue_pkg.sv | 27 ++
 rtl/operand_delivery_queue_if.sv | 31 +++
 rtl/operand_delivery_queue_op_pkt_fifo.sv | 54 +++++
 rtl/operand_delivery_queue.sv | 125 ++++++++++++
 tb/tb_operand_delivery_queue.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/operand_delivery_queue_pkg.sv
// Shared types for the E-node operand delivery queue.
package operand_delivery_queue_pkg;

    typedef logic [31:0] operand_t;
    typedef logic [6:0]  instr_num_t;

    localparam logic [1:0] SLOT_LEFT  = 2'd0;
    localparam logic [1:0] SLOT_RIGHT = 2'd1;
    localparam logic [1:0] SLOT_PRED  = 2'd2;

    typedef struct packed {
        operand_t   operand;
        instr_num_t dest_instr;
        logic [1:0] dest_slot;
    } operand_pkt_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_ACK
    } dlv_state_t;

    function automatic logic slot_legal(input logic [1:0] s);
        return s inside {SLOT_LEFT, SLOT_RIGHT, SLOT_PRED};
    endfunction

endpackage

// File: rtl/operand_delivery_queue_if.sv
// Router-side and station-side signals of the operand delivery queue.
interface operand_delivery_queue_if;
    import operand_delivery_queue_pkg::*;

    logic       net_valid;
    logic       net_ready;
    operand_t   net_operand;
    instr_num_t net_dest_instr;
    logic [1:0] net_dest_slot;

    logic       rs_req;
    operand_t   rs_operand;
    instr_num_t rs_dest_instr;
    logic [1:0] rs_dest_slot;
    logic       rs_ack;

    modport slave (
        input  net_valid, net_operand, net_dest_instr, net_dest_slot,
        input  rs_ack,
        output net_ready,
        output rs_req, rs_operand, rs_dest_instr, rs_dest_slot
    );

    modport master (
        output net_valid, net_operand, net_dest_instr, net_dest_slot,
        output rs_ack,
        input  net_ready,
        input  rs_req, rs_operand, rs_dest_instr, rs_dest_slot
    );

endinterface

// File: rtl/operand_delivery_queue_op_pkt_fifo.sv
// Packet FIFO with flush; head is combinational and zero when empty.
module op_pkt_fifo
    import operand_delivery_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    input  logic                    push,
    input  operand_pkt_t            din,
    input  logic                    pop,
    output operand_pkt_t            head,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    operand_pkt_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // storage needs no reset: head is masked while empty
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/operand_delivery_queue.sv
// Operand delivery queue: buffers router operand packets and hands
// them to the reservation station with ack timeout, retry and drop.
module operand_delivery_queue
    import operand_delivery_queue_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int ACK_TIMEOUT = 2,
    parameter int MAX_RETRY   = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    operand_delivery_queue_if.slave bus,
    input  logic                    flush,
    output logic [$clog2(DEPTH):0]  occupancy,
    output logic                    drop_pulse,
    output logic [7:0]              drop_count
);
    localparam int TW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    dlv_state_t   state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [RW-1:0] retry, retry_n;
    logic          pop;
    logic          drop;
    logic          full;
    logic          empty;
    operand_pkt_t  head;
    operand_pkt_t  din;

    assign din = '{operand:    bus.net_operand,
                   dest_instr: bus.net_dest_instr,
                   dest_slot:  bus.net_dest_slot};

    op_pkt_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (bus.net_valid && bus.net_ready),
        .din   (din),
        .pop   (pop),
        .head  (head),
        .count (occupancy),
        .full  (full),
        .empty (empty)
    );

    assign bus.net_ready     = !full;
    assign bus.rs_req        = (state == ST_ISSUE) && !flush;
    assign bus.rs_operand    = head.operand;
    assign bus.rs_dest_instr = head.dest_instr;
    assign bus.rs_dest_slot  = head.dest_slot;

    always_comb begin
        state_n = state;
        timer_n = timer;
        retry_n = retry;
        pop     = 1'b0;
        drop    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                timer_n = '0;
                retry_n = '0;
                if (!empty) begin
                    if (slot_legal(head.dest_slot)) begin
                        state_n = ST_ISSUE;
                    end else begin
                        pop  = 1'b1;
                        drop = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                timer_n = '0;
                state_n = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                // an ack on the timeout edge still counts as delivered
                if (bus.rs_ack) begin
                    pop     = 1'b1;
                    state_n = ST_IDLE;
                end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
                    timer_n = '0;
                    if (retry < RW'(MAX_RETRY)) begin
                        retry_n = retry + RW'(1);
                        state_n = ST_ISSUE;
                    end else begin
                        pop     = 1'b1;
                        drop    = 1'b1;
                        state_n = ST_IDLE;
                    end
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            default: state_n = ST_IDLE;
        endcase
        if (flush) begin
            state_n = ST_IDLE;
            timer_n = '0;
            retry_n = '0;
            pop     = 1'b0;
            drop    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            timer      <= '0;
            retry      <= '0;
            drop_pulse <= 1'b0;
            drop_count <= '0;
        end else begin
            state      <= state_n;
            timer      <= timer_n;
            retry      <= retry_n;
            drop_pulse <= drop;
            if (drop && drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_operand_delivery_queue.sv
// Bench for operand_delivery_queue: directed scenarios plus random
// traffic, every cycle compared against a queue-based reference model.
module tb_operand_delivery_queue;
    import operand_delivery_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int T     = 2;
    localparam int R     = 3;

    logic                   clk   = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   flush = 1'b0;
    logic [$clog2(DEPTH):0] occupancy;
    logic                   drop_pulse;
    logic [7:0]             drop_count;

    operand_delivery_queue_if bus();

    operand_delivery_queue #(
        .DEPTH(DEPTH), .ACK_TIMEOUT(T), .MAX_RETRY(R)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .flush      (flush),
        .occupancy  (occupancy),
        .drop_pulse (drop_pulse),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    // reference model: packet list plus cycles elapsed since the
    // head's first request (-1 = no delivery in progress)
    operand_pkt_t q[$];
    int  age      = -1;
    bit  exp_drop = 1'b0;
    int  exp_dcnt = 0;

    int  req_seen, drops_seen, first_req, last_req, max_occ, acc, dc;
    bit  prev_req = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic operand_pkt_t mk(input operand_t o,
                                        input instr_num_t d,
                                        input logic [1:0] s);
        return '{operand: o, dest_instr: d, dest_slot: s};
    endfunction

    task automatic model_reset();
        q.delete();
        age      = -1;
        exp_drop = 1'b0;
        exp_dcnt = 0;
    endtask

    task automatic model_step(input logic v, input operand_pkt_t p,
                              input logic ack, input logic fl);
        bit do_pop, do_drop, accept;
        do_pop  = 1'b0;
        do_drop = 1'b0;
        accept  = v && (q.size() < DEPTH);
        if (fl) begin
            q.delete();
            age      = -1;
            exp_drop = 1'b0;
        end else begin
            if (age < 0) begin
                if (q.size() > 0) begin
                    if (q[0].dest_slot == 2'd3) begin
                        do_pop  = 1'b1;
                        do_drop = 1'b1;
                    end else begin
                        age = 0;
                    end
                end
            end else if ((age % (T + 1)) != 0 && ack) begin
                do_pop = 1'b1;
                age    = -1;
            end else if (age == (R + 1) * (T + 1) - 1) begin
                do_pop  = 1'b1;
                do_drop = 1'b1;
                age     = -1;
            end else begin
                age++;
            end
            if (do_pop) void'(q.pop_front());
            if (accept) q.push_back(p);
            exp_drop = do_drop;
            if (do_drop && exp_dcnt < 255) exp_dcnt++;
        end
    endtask

    task automatic cyc(input logic v, input operand_pkt_t p,
                       input logic ack, input logic fl);
        operand_pkt_t h;
        bit           ereq;
        bus.net_valid      = v;
        bus.net_operand    = p.operand;
        bus.net_dest_instr = p.dest_instr;
        bus.net_dest_slot  = p.dest_slot;
        bus.rs_ack         = ack;
        flush              = fl;
        #1;
        h    = (q.size() > 0) ? q[0] : '0;
        ereq = !fl && age >= 0 && (age % (T + 1)) == 0;
        chk("rs_req", 64'(bus.rs_req), 64'(ereq));
        chk("payload",
            64'({bus.rs_operand, bus.rs_dest_instr, bus.rs_dest_slot}),
            64'(h));
        chk("occupancy", 64'(occupancy), 64'(q.size()));
        chk("net_ready", 64'(bus.net_ready), 64'(q.size() < DEPTH));
        chk("drop_pulse", 64'(drop_pulse), 64'(exp_drop));
        chk("drop_count", 64'(drop_count), 64'(exp_dcnt));
        if (bus.rs_req) begin
            req_seen++;
            if (first_req < 0) first_req = cycle;
            last_req = cycle;
        end
        if (drop_pulse) drops_seen++;
        if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
        prev_req = bus.rs_req;
        @(posedge clk);
        model_step(v, p, ack, fl);
        cycle++;
        #1;
    endtask

    task automatic idle(input int n, input bit auto_ack);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, '0, auto_ack ? prev_req : 1'b0, 1'b0);
        end
    endtask

    task automatic clr_stats();
        req_seen   = 0;
        drops_seen = 0;
        first_req  = -1;
        last_req   = -1;
        max_occ    = 0;
    endtask

    initial begin
        bus.net_valid      = 1'b0;
        bus.net_operand    = '0;
        bus.net_dest_instr = '0;
        bus.net_dest_slot  = '0;
        bus.rs_ack         = 1'b0;
        clr_stats();

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 64'(bus.rs_req), 64'd0);
        chk("rst_ready", 64'(bus.net_ready), 64'd1);
        chk("rst_occ", 64'(occupancy), 64'd0);
        chk("rst_dcnt", 64'(drop_count), 64'd0);
        rst_n = 1'b1;
        model_reset();
        idle(2, 1'b0);

        // single packet, acked the cycle after the request
        clr_stats();
        acc = cycle;
        cyc(1'b1, mk(32'hA5, 7'd5, 2'd1), 1'b0, 1'b0);
        idle(2, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        idle(1, 1'b0);
        chk("single_reqs", 64'(req_seen), 64'd1);
        chk("single_lat", 64'(first_req - acc), 64'd2);
        chk("single_occ", 64'(occupancy), 64'd0);
        chk("single_drops", 64'(drops_seen), 64'd0);

        // station never acks: four requests then a drop
        clr_stats();
        cyc(1'b1, mk(32'h1234, 7'd9, 2'd0), 1'b0, 1'b0);
        idle(16, 1'b0);
        chk("tmo_reqs", 64'(req_seen), 64'd4);
        chk("tmo_span", 64'(last_req - first_req), 64'd9);
        chk("tmo_drops", 64'(drops_seen), 64'd1);
        chk("tmo_dcnt", 64'(drop_count), 64'd1);
        chk("tmo_occ", 64'(occupancy), 64'd0);

        // fill while stalled, then drain with acks
        clr_stats();
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b1, mk(32'(100 + i), 7'(i), 2'(i % 3)), 1'b0, 1'b0);
        end
        chk("full_ready", 64'(bus.net_ready), 64'd0);
        chk("full_occ", 64'(occupancy), 64'(DEPTH));
        cyc(1'b1, mk(32'hDEAD, 7'd1, 2'd0), 1'b0, 1'b0);
        idle(30, 1'b1);
        chk("fill_max", 64'(max_occ), 64'(DEPTH));
        chk("fill_occ", 64'(occupancy), 64'd0);
        chk("fill_drops", 64'(drops_seen), 64'd0);

        // illegal slot between two legal packets
        clr_stats();
        cyc(1'b1, mk(32'h11, 7'd1, 2'd0), 1'b0, 1'b0);
        cyc(1'b1, mk(32'h22, 7'd2, 2'd3), 1'b0, 1'b0);
        cyc(1'b1, mk(32'h33, 7'd3, 2'd2), prev_req, 1'b0);
        idle(25, 1'b1);
        chk("ill_reqs", 64'(req_seen), 64'd2);
        chk("ill_drops", 64'(drops_seen), 64'd1);
        chk("ill_dcnt", 64'(drop_count), 64'd2);

        // flush while waiting for an ack with three queued
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, mk(32'(200 + i), 7'(20 + i), 2'd1), 1'b0, 1'b0);
        end
        for (int g = 0; g < 10; g++) begin
            if (age > 0 && (age % (T + 1)) != 0) break;
            cyc(1'b0, '0, 1'b0, 1'b0);
        end
        chk("pre_flush_occ", 64'(occupancy), 64'd3);
        dc = exp_dcnt;
        clr_stats();
        cyc(1'b1, mk(32'hBEEF, 7'd7, 2'd0), 1'b0, 1'b1);
        chk("flush_occ", 64'(occupancy), 64'd0);
        chk("flush_req", 64'(bus.rs_req), 64'd0);
        chk("flush_dcnt", 64'(drop_count), 64'(dc));
        cyc(1'b0, '0, 1'b1, 1'b0);
        idle(3, 1'b0);
        chk("flush_noreq", 64'(req_seen), 64'd0);
        chk("flush_late_occ", 64'(occupancy), 64'd0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            logic [1:0] sl;
            logic       ak;
            sl = ($urandom_range(0, 7) == 0) ? 2'd3
                                             : 2'($urandom_range(0, 2));
            ak = prev_req ? ($urandom_range(0, 3) != 0)
                          : ($urandom_range(0, 9) == 0);
            cyc(1'($urandom_range(0, 1)),
                mk($urandom, 7'($urandom), sl), ak,
                $urandom_range(0, 39) == 0);
        end

        // asynchronous reset while in ISSUE
        cyc(1'b0, '0, 1'b0, 1'b1);
        idle(2, 1'b0);
        cyc(1'b1, mk(32'hCAFE, 7'd3, 2'd2), 1'b0, 1'b0);
        for (int g = 0; g < 10; g++) begin
            if (age == 0) break;
            cyc(1'b0, '0, 1'b0, 1'b0);
        end
        chk("arst_pre_req", 64'(bus.rs_req), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req", 64'(bus.rs_req), 64'd0);
        chk("arst_occ", 64'(occupancy), 64'd0);
        chk("arst_ready", 64'(bus.net_ready), 64'd1);
        chk("arst_dcnt", 64'(drop_count), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        idle(3, 1'b0);
        chk("post_rst_ready", 64'(bus.net_ready), 64'd1);
        chk("post_rst_occ", 64'(occupancy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
